// File: rtl/dp_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered compute datapath among NUM_REQ requesters.
// One request is served at a time: operand/select are held for LATENCY+1 cycles, then the result returns with a done pulse.
module dp_arbiter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_op,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         dp_data,
  output logic                     dp_sel,
  input  logic [WIDTH-1:0]         dp_result,
  output logic [WIDTH-1:0]         result,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic                     busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int unsigned CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    r_last_id;
  logic [NUM_REQ-1:0] r_gnt;
  logic [WIDTH-1:0]   r_dp_data;
  logic               r_dp_sel;
  logic [WIDTH-1:0]   r_result;
  logic               r_done;
  logic [ID_W-1:0]    r_done_id;
  logic               r_busy;

  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [ID_W-1:0]    w_last_id_nxt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [WIDTH-1:0]   w_dp_data_nxt;
  logic               w_dp_sel_nxt;
  logic [WIDTH-1:0]   w_result_nxt;
  logic               w_done_nxt;
  logic [ID_W-1:0]    w_done_id_nxt;
  logic               w_busy_nxt;

  logic               w_win_found;
  logic [ID_W-1:0]    w_win_id;
  int unsigned        w_best_off;
  logic [WIDTH-1:0]   w_win_data;
  logic               w_win_op;

  // Round-robin pick: smallest distance from last_id+1 (with wrap) among active requests.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_best_off  = NUM_REQ;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (req[k] && (((k + NUM_REQ - 1 - 32'(r_last_id)) % NUM_REQ) < w_best_off)) begin
        w_best_off  = (k + NUM_REQ - 1 - 32'(r_last_id)) % NUM_REQ;
        w_win_id    = ID_W'(k);
        w_win_found = 1'b1;
      end
    end
  end

  // Operand and mode select of the winning requester.
  always_comb begin
    w_win_data = '0;
    w_win_op   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_win_id == ID_W'(k)) begin
        w_win_data = req_data[k*WIDTH +: WIDTH];
        w_win_op   = req_op[k];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_last_id_nxt = r_last_id;
    w_gnt_nxt     = r_gnt;
    w_dp_data_nxt = r_dp_data;
    w_dp_sel_nxt  = r_dp_sel;
    w_result_nxt  = r_result;
    w_done_nxt    = 1'b0;
    w_done_id_nxt = r_done_id;
    w_busy_nxt    = r_busy;

    case (r_state)
      S_IDLE: begin
        w_gnt_nxt     = '0;
        w_dp_data_nxt = '0;
        w_dp_sel_nxt  = 1'b0;
        w_busy_nxt    = 1'b0;
        if (w_win_found) begin
          w_state_nxt   = S_SERVE;
          w_gnt_nxt     = NUM_REQ'(1) << w_win_id;
          w_dp_data_nxt = w_win_data;
          w_dp_sel_nxt  = w_win_op;
          w_last_id_nxt = w_win_id;
          w_cnt_nxt     = '0;
          w_busy_nxt    = 1'b1;
        end
      end
      S_SERVE: begin
        if (r_cnt == CNT_W'(LATENCY)) begin
          w_state_nxt   = S_DONE;
          w_result_nxt  = dp_result;
          w_gnt_nxt     = '0;
          w_dp_data_nxt = '0;
          w_dp_sel_nxt  = 1'b0;
          w_done_nxt    = 1'b1;
          w_done_id_nxt = r_last_id;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_cnt_nxt     = '0;
        w_gnt_nxt     = '0;
        w_dp_data_nxt = '0;
        w_dp_sel_nxt  = 1'b0;
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset also aborts any in-flight service.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last_id <= ID_W'(NUM_REQ - 1);
      r_gnt     <= '0;
      r_dp_data <= '0;
      r_dp_sel  <= 1'b0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last_id <= w_last_id_nxt;
      r_gnt     <= w_gnt_nxt;
      r_dp_data <= w_dp_data_nxt;
      r_dp_sel  <= w_dp_sel_nxt;
      r_result  <= w_result_nxt;
      r_done    <= w_done_nxt;
      r_done_id <= w_done_id_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign dp_data = r_dp_data;
  assign dp_sel  = r_dp_sel;
  assign result  = r_result;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign busy    = r_busy;

endmodule

// File: tb/tb_dp_arbiter.sv
// Directed bench for dp_arbiter (WIDTH=4, NUM_REQ=4, LATENCY=1) with a registered increment/invert datapath model.
module tb_dp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  req_op;
  logic [3:0]  gnt;
  logic [3:0]  dp_data;
  logic        dp_sel;
  logic [3:0]  dp_result;
  logic [3:0]  result;
  logic        done;
  logic [1:0]  done_id;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  dp_arbiter #(
    .WIDTH(4), .NUM_REQ(4), .LATENCY(1), .ID_W(2)
  ) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_op(req_op),
    .gnt(gnt), .dp_data(dp_data), .dp_sel(dp_sel), .dp_result(dp_result),
    .result(result), .done(done), .done_id(done_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath: registered increment (sel=0) or invert (sel=1).
  always @(posedge clk) begin
    if (rst) dp_result <= 4'h0;
    else     dp_result <= dp_sel ? ~dp_data : dp_data + 4'h1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Enter from IDLE cycle T0 with req set; returns in T4 (IDLE again).
  task automatic svc(input logic [1:0] id, input logic [3:0] d, input logic s,
                     input logic [3:0] res, input logic [3:0] drop);
    logic [3:0] g;
    g = 4'b0001 << id;
    tick();
    check("t1_gnt", 32'(gnt), 32'(g));
    check("t1_data", 32'(dp_data), 32'(d));
    check("t1_sel", 32'(dp_sel), 32'(s));
    check("t1_busy", 32'(busy), 32'(1));
    req = req & ~drop;
    tick();
    check("t2_gnt", 32'(gnt), 32'(g));
    check("t2_done", 32'(done), 32'(0));
    tick();
    check("t3_done", 32'(done), 32'(1));
    check("t3_id", 32'(done_id), 32'(id));
    check("t3_result", 32'(result), 32'(res));
    check("t3_gnt", 32'(gnt), 32'(0));
    check("t3_data", 32'(dp_data), 32'(0));
    check("t3_busy", 32'(busy), 32'(1));
    tick();
    check("t4_done", 32'(done), 32'(0));
    check("t4_busy", 32'(busy), 32'(0));
    check("t4_result", 32'(result), 32'(res));
  endtask

  initial begin
    rst      = 1'b1;
    req      = 4'b1111;
    req_data = {4'hF, 4'hA, 4'h7, 4'h3};
    req_op   = 4'b0100;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_data", 32'(dp_data), 32'(0));
    check("rst_sel", 32'(dp_sel), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_id", 32'(done_id), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;

    // Fairness with all requests held: 0,1,2,3,0
    svc(2'd0, 4'h3, 1'b0, 4'h4, 4'b0000);
    svc(2'd1, 4'h7, 1'b0, 4'h8, 4'b0000);
    svc(2'd2, 4'hA, 1'b1, 4'h5, 4'b0000);
    svc(2'd3, 4'hF, 1'b0, 4'h0, 4'b0000);
    svc(2'd0, 4'h3, 1'b0, 4'h4, 4'b1111);

    // Idle with no requests
    tick();
    check("idle_gnt", 32'(gnt), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));

    // Single request
    req = 4'b0001;
    svc(2'd0, 4'h3, 1'b0, 4'h4, 4'b0001);

    // Wrap: serve 2, then 0101 -> 0 then 2
    req = 4'b0100;
    svc(2'd2, 4'hA, 1'b1, 4'h5, 4'b0000);
    req = 4'b0101;
    svc(2'd0, 4'h3, 1'b0, 4'h4, 4'b0000);
    svc(2'd2, 4'hA, 1'b1, 4'h5, 4'b0101);

    // Requester 1 drops req in T1
    req = 4'b0010;
    svc(2'd1, 4'h7, 1'b0, 4'h8, 4'b0010);

    // Reset in T1 of a service for requester 3
    req = 4'b1000;
    tick();
    check("mid_gnt3", 32'(gnt), 32'(4'b1000));
    rst = 1'b1;
    tick();
    check("mid_rst_gnt", 32'(gnt), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_done", 32'(done), 32'(0));
    check("mid_rst_result", 32'(result), 32'(0));
    rst = 1'b0;
    req = 4'b1001;
    tick();
    check("post_rst_gnt", 32'(gnt), 32'(4'b0001));
    check("post_rst_done", 32'(done), 32'(0));
    req = 4'b0000;
    tick();
    check("post_rst_done2", 32'(done), 32'(0));
    tick();
    check("post_rst_done3", 32'(done), 32'(1));
    check("post_rst_id", 32'(done_id), 32'(0));
    check("post_rst_result", 32'(result), 32'(4'h4));
    tick();
    check("post_rst_idle", 32'(busy), 32'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dp_arbiter.md
# dp_arbiter

Round-robin arbiter and sequencer that shares one registered 4-bit compute datapath (operand input, mode select, registered result) among several requesters. It accepts one request at a time and drives the operand and select lines for a fixed latency window. It captures the datapath result and returns it to the granted requester with a one-cycle done pulse. It sits between requester blocks and the datapath instance.

## Interface
- WIDTH, 4, operand/result width; matches datapath data width
- NUM_REQ, 4, number of requesters (2..8)
- LATENCY, 1, datapath input-to-registered-output latency in cycles (1..4)
- ID_W, $clog2(NUM_REQ), width of done_id

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- req  in  NUM_REQ  per-requester request, level
- req_data  in  NUM_REQ*WIDTH  packed operands; requester i at [i*WIDTH +: WIDTH]
- req_op  in  NUM_REQ  per-requester mode select (0: increment mode, 1: invert mode)
- gnt  out  NUM_REQ  one-hot grant, held for whole service window
- dp_data  out  WIDTH  operand to datapath
- dp_sel  out  1  mode select to datapath
- dp_result  in  WIDTH  datapath registered output
- result  out  WIDTH  captured result
- done  out  1  one-cycle pulse; result and done_id valid
- done_id  out  ID_W  index of served requester
- busy  out  1  high while a service is in progress (SERVE or DONE)

## Operation
- FSM states: IDLE, SERVE, DONE.
- IDLE: if any req bit is high, select the winner round-robin. Search starts at (last_id+1) mod NUM_REQ, ascending with wrap. Register the winner's req_data slice into dp_data and its req_op bit into dp_sel. Set gnt one-hot, set last_id to the winner, load the counter with 0, and go to SERVE. If no req bit is high, stay in IDLE.
- SERVE: lasts LATENCY+1 cycles. dp_data, dp_sel and gnt are held constant; requester inputs are not re-sampled. On the last SERVE cycle, capture dp_result into result and go to DONE.
- DONE: done=1 and done_id=last_id for exactly one cycle. gnt=0 and dp_data/dp_sel return to 0. Go to IDLE. No arbitration happens in DONE.
- gnt, dp_data and dp_sel are 0 in IDLE and DONE.
- result holds its value until the next capture.
- If a requester drops req during SERVE, the service still completes and done still pulses.
- A requester that holds req high after done is re-eligible, at lowest priority behind all others.
- Unused/illegal state encodings recover to IDLE.

## Timing
- Reset (rst high at a clock edge) forces the following, whether idle or mid-service:
  - state=IDLE, gnt=0, dp_data=0, dp_sel=0, result=0, done=0, done_id=0, busy=0
  - last_id=NUM_REQ-1, so requester 0 has top priority after reset
- An in-flight service aborted by reset produces no done.
- req sampled high in IDLE cycle T0 gives:
  - gnt, dp_data, dp_sel and busy valid in cycles T1..T(LATENCY+1)
  - result captured at the end of T(LATENCY+1)
  - done in T(LATENCY+2)
  - IDLE in T(LATENCY+3)
- Back-to-back grant spacing is LATENCY+3 cycles. With LATENCY=1, a new grant is possible every 4 cycles.
- Arbitration is purely combinational on the IDLE-cycle req value. All outputs are registered.

## Test plan
- Reset: rst=1 for 2 cycles with req=4'b1111 -> all outputs 0 and busy=0; first grant after release goes to requester 0.
- Single request: LATENCY=1; bench datapath model registers dp_data+1 when dp_sel=0. req=4'b0001, slice 0=4'h3, op=0 -> gnt=0001 in T1..T2, dp_data=4'h3, result=4'h4 with done=1 and done_id=0 in T3.
- Fairness: req=4'b1111 held continuously -> grants 0,1,2,3,0 at 4-cycle spacing, one done per grant.
- Wrap: after requester 2 is served, req=4'b0101 -> next grant is requester 0 (search order 3,0), then requester 2.
- Drop mid-service: requester 1 deasserts req in T1 -> gnt stays high through T2, done=1 with done_id=1 in T3.
- Reset mid-operation: rst=1 in T1 of a service for requester 3 -> next cycle gnt=0, busy=0, no done pulse; with req=4'b1001 the next grant goes to requester 0.
